id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
//  Decode->execute pipeline stage directly downstream of the register file.
//  Captures the register file's combinational rs1/rs2 read data plus decoded
//  fields into the ID/EX register. Resolves RAW hazards by forwarding or stalling.
//  Valid/ready handshake on both sides; synchronous flush from branch/trap logic.
// PARAMETERS
//  DATA_SIZE   32  operand / pc / immediate width
//  CTRL_W      16  opaque decoded-control bundle width (passed through)
// PORTS
//  clk             in   1          clock
//  rst             in   1          async reset, active-low (0 = reset)
//  id_valid        in   1          decode holds an instruction
//  id_ready        out  1          stage accepts it this cycle
//  id_pc/id_imm    in   DATA_SIZE  pc, sign-extended immediate
//  id_ctrl         in   CTRL_W     decoded control
//  id_rs1_addr     in   5          source 1 (also drives register file rs1_addr)
//  id_rs2_addr     in   5          source 2 (also drives register file rs2_addr)
//  id_rd_addr      in   5          destination
//  id_uses_rs1/2   in   1 each     operand actually read
//  id_reg_write    in   1          instruction writes rd
//  id_is_load      in   1          instruction is a load
//  rf_rs1_data     in   DATA_SIZE  register file read data 1
//  rf_rs2_data     in   DATA_SIZE  register file read data 2
//  exmem_rd_addr   in   5          EX/MEM rd; exmem_reg_write, exmem_is_load: 1 each
//  exmem_result    in   DATA_SIZE  EX/MEM ALU result
//  memwb_rd_addr   in   5          MEM/WB rd (same as register file write port)
//  memwb_reg_write in   1          MEM/WB writes rd
//  memwb_data      in   DATA_SIZE  write-back data
//  flush           in   1          kill ID/EX contents
//  ex_ready        in   1          execute accepts
//  ex_valid        out  1          ID/EX holds valid instruction
//  ex_pc/ex_imm/ex_rs1_data/ex_rs2_data  out  DATA_SIZE  registered
//  ex_ctrl         out  CTRL_W     registered
//  ex_rd_addr      out  5          registered
//  ex_reg_write/ex_is_load  out  1 each  registered
// BEHAVIOUR
//  - Reset (rst=0, async): every ex_* output is 0, incl. ex_valid; id_ready is 0 while rst=0.
//  - advance = ~ex_valid | ex_ready. id_ready = advance & ~hazard & ~flush.
//  - Edge, priority order:
//    - flush -> ex_valid<=0, wins over all.
//    - else id_valid&id_ready -> capture all fields, ex_valid<=1.
//    - else advance -> ex_valid<=0 (bubble).
//    - else hold every output unchanged.
//  - Latency 1 cycle ID->EX. Outputs are stable while ex_valid&~ex_ready.
//  - match(s,rd,we) = uses_s & we & rd==addr_s & addr_s!=0.
//  - Operand select, per source:
//    - addr=0 -> 0
//    - elif EX/MEM match & ~exmem_is_load -> exmem_result
//    - elif MEM/WB match -> memwb_data
//    - else rf data
//    - MEM/WB forward is mandatory: the register file writes at the same edge as capture.
//  - hazard: any match vs ID/EX (ex_valid&ex_reg_write), or vs EX/MEM with exmem_is_load.
//    Load-use penalty is 2 cycles; ALU-use penalty is 1 cycle.
//  - Reset mid-stall or mid-hold: all state cleared, no replay.
// CONFIGURATION
//  ID_EX_FWD_EN defined: forwarding as above.
//  ID_EX_FWD_EN undefined: operands always rf data (x0 still 0).
//    hazard = any match vs ID/EX, EX/MEM, or MEM/WB stage, regardless of load.
// STRUCTURE
//  cpu_pipe_pkg: fwd_sel_e {FWD_RF,FWD_EXMEM,FWD_MEMWB,FWD_ZERO}, REG_ADDR_W=5, X0=5'd0.
//  Sub-module id_ex_fwd_unit: per-source match/select/hazard logic (combinational).
//  Top holds the ID/EX register and handshake.
// TESTING
//  1 rst=0 while ex_valid=1, ex_ready=0 -> all ex_* 0 immediately; id_ready=0.
//  2 rf 0x11/0x22, no matches, ex_ready=1 -> next edge ex_valid=1, data 0x11/0x22.
//  3 exmem rd=5 res 0xDEAD and memwb rd=5 data 0xBEEF, rs1=5 -> ex_rs1_data=0xDEAD.
//  4 ID/EX load rd=7, id rs2=7 -> id_ready=0 2 cycles, 2 bubbles, then ex_rs2_data=memwb_data.
//  5 rs1=0, exmem rd=0 res 0xFF -> ex_rs1_data=0, no stall.
//  6 ex_ready=0 for 3 cycles -> outputs stable; flush with ex_ready=0 -> ex_valid=0 next edge.
//  Repeat 3-4 without ID_EX_FWD_EN -> 3 stalls; data from rf after write.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline types: register address width, x0 constant, operand-select
// encoding and the source/destination match helper used by hazard logic.
package cpu_pipe_pkg;

   localparam int REG_ADDR_W = 5;
   localparam logic [REG_ADDR_W-1:0] X0 = 5'd0;

   typedef enum logic [1:0] {
      FWD_RF    = 2'd0,
      FWD_EXMEM = 2'd1,
      FWD_MEMWB = 2'd2,
      FWD_ZERO  = 2'd3
   } fwd_sel_e;

   // A source depends on a producer only if it is really read, the producer
   // really writes, the addresses agree and the address is not x0.
   function automatic logic src_match(
      input logic                  uses,
      input logic [REG_ADDR_W-1:0] addr,
      input logic [REG_ADDR_W-1:0] rd,
      input logic                  we
   );
      return uses & we & (rd == addr) & (addr != X0);
   endfunction

endpackage

// File: rtl/id_ex_fwd_unit.sv
// Per-source RAW dependency check, operand select and hazard detection.
// ID_EX_FWD_EN selects forwarding; otherwise every dependency stalls.
module id_ex_fwd_unit
   import cpu_pipe_pkg::*;
#(
   parameter int DATA_SIZE = 32
) (
   input  logic                  uses_rs1,
   input  logic                  uses_rs2,
   input  logic [REG_ADDR_W-1:0] rs1_addr,
   input  logic [REG_ADDR_W-1:0] rs2_addr,
   input  logic [DATA_SIZE-1:0]  rf_rs1_data,
   input  logic [DATA_SIZE-1:0]  rf_rs2_data,
   input  logic                  idex_valid,
   input  logic                  idex_reg_write,
   input  logic [REG_ADDR_W-1:0] idex_rd_addr,
   input  logic [REG_ADDR_W-1:0] exmem_rd_addr,
   input  logic                  exmem_reg_write,
   input  logic                  exmem_is_load,
   input  logic [DATA_SIZE-1:0]  exmem_result,
   input  logic [REG_ADDR_W-1:0] memwb_rd_addr,
   input  logic                  memwb_reg_write,
   input  logic [DATA_SIZE-1:0]  memwb_data,
   output logic [DATA_SIZE-1:0]  rs1_data,
   output logic [DATA_SIZE-1:0]  rs2_data,
   output logic                  hazard
);

   logic [1:0]            uses_v;
   logic [REG_ADDR_W-1:0] addr_v [2];
   logic [DATA_SIZE-1:0]  rf_v   [2];
   logic [DATA_SIZE-1:0]  op_v   [2];
   fwd_sel_e              sel_v  [2];
   logic [1:0]            m_idex;
   logic [1:0]            m_exmem;
   logic [1:0]            m_memwb;

   assign uses_v    = {uses_rs2, uses_rs1};
   assign addr_v[0] = rs1_addr;
   assign addr_v[1] = rs2_addr;
   assign rf_v[0]   = rf_rs1_data;
   assign rf_v[1]   = rf_rs2_data;

   always_comb begin
      m_idex  = '0;
      m_exmem = '0;
      m_memwb = '0;
      for (int s = 0; s < 2; s++) begin
         m_idex[s]  = src_match(uses_v[s], addr_v[s], idex_rd_addr,
                                idex_valid & idex_reg_write);
         m_exmem[s] = src_match(uses_v[s], addr_v[s], exmem_rd_addr, exmem_reg_write);
         m_memwb[s] = src_match(uses_v[s], addr_v[s], memwb_rd_addr, memwb_reg_write);
      end
   end

`ifdef ID_EX_FWD_EN
   // EX/MEM is younger than MEM/WB, so it wins when both hold the same rd.
   always_comb begin
      for (int s = 0; s < 2; s++) begin
         sel_v[s] = FWD_RF;
         if (addr_v[s] == X0)
            sel_v[s] = FWD_ZERO;
         else if (m_exmem[s] & ~exmem_is_load)
            sel_v[s] = FWD_EXMEM;
         else if (m_memwb[s])
            sel_v[s] = FWD_MEMWB;
      end
   end

   assign hazard = (|m_idex) | ((|m_exmem) & exmem_is_load);
`else
   always_comb begin
      for (int s = 0; s < 2; s++) begin
         sel_v[s] = (addr_v[s] == X0) ? FWD_ZERO : FWD_RF;
      end
   end

   assign hazard = (|m_idex) | (|m_exmem) | (|m_memwb);
`endif

   always_comb begin
      for (int s = 0; s < 2; s++) begin
         op_v[s] = rf_v[s];
         case (sel_v[s])
            FWD_ZERO:  op_v[s] = '0;
            FWD_EXMEM: op_v[s] = exmem_result;
            FWD_MEMWB: op_v[s] = memwb_data;
            default:   op_v[s] = rf_v[s];
         endcase
      end
   end

   assign rs1_data = op_v[0];
   assign rs2_data = op_v[1];

   // Forwarded data and load flag are only consumed in some build variants.
   logic unused_fwd_inputs;
   assign unused_fwd_inputs = ^{exmem_result, memwb_data, exmem_is_load};

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshake, flush and RAW hazard
// handling. Forwarding is enabled by defining ID_EX_FWD_EN.
module id_ex_stage
   import cpu_pipe_pkg::*;
#(
   parameter int DATA_SIZE = 32,
   parameter int CTRL_W    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid,
   output logic                  id_ready,
   input  logic [DATA_SIZE-1:0]  id_pc,
   input  logic [DATA_SIZE-1:0]  id_imm,
   input  logic [CTRL_W-1:0]     id_ctrl,
   input  logic [REG_ADDR_W-1:0] id_rs1_addr,
   input  logic [REG_ADDR_W-1:0] id_rs2_addr,
   input  logic [REG_ADDR_W-1:0] id_rd_addr,
   input  logic                  id_uses_rs1,
   input  logic                  id_uses_rs2,
   input  logic                  id_reg_write,
   input  logic                  id_is_load,
   input  logic [DATA_SIZE-1:0]  rf_rs1_data,
   input  logic [DATA_SIZE-1:0]  rf_rs2_data,
   input  logic [REG_ADDR_W-1:0] exmem_rd_addr,
   input  logic                  exmem_reg_write,
   input  logic                  exmem_is_load,
   input  logic [DATA_SIZE-1:0]  exmem_result,
   input  logic [REG_ADDR_W-1:0] memwb_rd_addr,
   input  logic                  memwb_reg_write,
   input  logic [DATA_SIZE-1:0]  memwb_data,
   input  logic                  flush,
   input  logic                  ex_ready,
   output logic                  ex_valid,
   output logic [DATA_SIZE-1:0]  ex_pc,
   output logic [DATA_SIZE-1:0]  ex_imm,
   output logic [DATA_SIZE-1:0]  ex_rs1_data,
   output logic [DATA_SIZE-1:0]  ex_rs2_data,
   output logic [CTRL_W-1:0]     ex_ctrl,
   output logic [REG_ADDR_W-1:0] ex_rd_addr,
   output logic                  ex_reg_write,
   output logic                  ex_is_load
);

   logic                 advance;
   logic                 hazard;
   logic                 accept;
   logic [DATA_SIZE-1:0] op_rs1;
   logic [DATA_SIZE-1:0] op_rs2;

   id_ex_fwd_unit #(
      .DATA_SIZE (DATA_SIZE)
   ) u_fwd (
      .uses_rs1        (id_uses_rs1),
      .uses_rs2        (id_uses_rs2),
      .rs1_addr        (id_rs1_addr),
      .rs2_addr        (id_rs2_addr),
      .rf_rs1_data     (rf_rs1_data),
      .rf_rs2_data     (rf_rs2_data),
      .idex_valid      (ex_valid),
      .idex_reg_write  (ex_reg_write),
      .idex_rd_addr    (ex_rd_addr),
      .exmem_rd_addr   (exmem_rd_addr),
      .exmem_reg_write (exmem_reg_write),
      .exmem_is_load   (exmem_is_load),
      .exmem_result    (exmem_result),
      .memwb_rd_addr   (memwb_rd_addr),
      .memwb_reg_write (memwb_reg_write),
      .memwb_data      (memwb_data),
      .rs1_data        (op_rs1),
      .rs2_data        (op_rs2),
      .hazard          (hazard)
   );

   // Handshake: a transfer happens on an edge where valid & ready are both 1;
   // the producer holds valid and payload stable until then, and ready never
   // depends on a valid of the same side.
   assign advance  = ~ex_valid | ex_ready;
   assign id_ready = rst & advance & ~hazard & ~flush;
   assign accept   = id_valid & id_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_valid     <= 1'b0;
         ex_pc        <= '0;
         ex_imm       <= '0;
         ex_rs1_data  <= '0;
         ex_rs2_data  <= '0;
         ex_ctrl      <= '0;
         ex_rd_addr   <= '0;
         ex_reg_write <= 1'b0;
         ex_is_load   <= 1'b0;
      end else if (flush) begin
         ex_valid <= 1'b0;
      end else if (accept) begin
         ex_valid     <= 1'b1;
         ex_pc        <= id_pc;
         ex_imm       <= id_imm;
         ex_rs1_data  <= op_rs1;
         ex_rs2_data  <= op_rs2;
         ex_ctrl      <= id_ctrl;
         ex_rd_addr   <= id_rd_addr;
         ex_reg_write <= id_reg_write;
         ex_is_load   <= id_is_load;
      end else if (advance) begin
         ex_valid <= 1'b0;
      end
   end

endmodule
